// File: rtl/simd_upstream_intf_pkg.sv
// simd_upstream_intf_pkg
// Shared definitions for the SIMD upstream packetizer: upstream control
// encodings, header word type, header/OOB field offsets and FSM states.
package simd_upstream_intf_pkg;

   // sui__sti__cntl encodings
   localparam logic [1:0] CNTL_MOP = 2'b00;
   localparam logic [1:0] CNTL_SOP = 2'b01;
   localparam logic [1:0] CNTL_EOP = 2'b10;

   // sui__sti__type value carried by the header word
   localparam logic [1:0] TYPE_HDR = 2'b11;

   // Header data word: {zeros, peId, tag, count}
   localparam int unsigned HDR_CNT_LSB  = 0;
   localparam int unsigned HDR_TAG_LSB  = 8;
   localparam int unsigned HDR_PEID_LSB = 16;

   // Header OOB word: {peId, tag, count[7:0], 8'h00}
   localparam int unsigned OOB_CNT_LSB  = 8;
   localparam int unsigned OOB_TAG_LSB  = 16;
   localparam int unsigned OOB_PEID_LSB = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } sui_state_e;

endpackage

// File: rtl/simd_upstream_intf_if.sv
// simd_upstream_intf_if
// Bundles the SIMD result handshake (simd__sui__* / sui__simd__ready) and
// the stack interface upstream port (sui__sti__* / sti__sui__ready).
//   slave  : packetizer view (consumes SIMD words, produces upstream words)
//   master : environment view (SIMD producer plus stack interface consumer)
interface simd_upstream_intf_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned OOB_W  = 32
);
   logic              simd__sui__valid;
   logic              sui__simd__ready;
   logic [DATA_W-1:0] simd__sui__data;
   logic [1:0]        simd__sui__type;
   logic              simd__sui__last;
   logic [7:0]        simd__sui__tag;

   logic              sui__sti__valid;
   logic [1:0]        sui__sti__cntl;
   logic              sti__sui__ready;
   logic [1:0]        sui__sti__type;
   logic [DATA_W-1:0] sui__sti__data;
   logic [OOB_W-1:0]  sui__sti__oob_data;

   modport slave (
      input  simd__sui__valid, simd__sui__data, simd__sui__type,
             simd__sui__last, simd__sui__tag, sti__sui__ready,
      output sui__simd__ready, sui__sti__valid, sui__sti__cntl,
             sui__sti__type, sui__sti__data, sui__sti__oob_data
   );

   modport master (
      output simd__sui__valid, simd__sui__data, simd__sui__type,
             simd__sui__last, simd__sui__tag, sti__sui__ready,
      input  sui__simd__ready, sui__sti__valid, sui__sti__cntl,
             sui__sti__type, sui__sti__data, sui__sti__oob_data
   );
endinterface

// File: rtl/simd_upstream_fifo.sv
// simd_upstream_fifo
// Generic synchronous FIFO with first-word fall-through read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full)
//   pop, dout  : read request (ignored when empty) and head entry
//   full, empty, count : occupancy status; count is $clog2(DEPTH)+1 bits
// Simultaneous push and pop leaves count unchanged.
module simd_upstream_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             wr_en, rd_en;

   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/simd_upstream_intf.sv
// simd_upstream_intf
// Store-and-forward packetizer from the PE SIMD result path to the stack
// interface upstream port. Each packet goes out as one header word (SOP)
// followed by its data words (MOP..., EOP).
//   clk, reset_poweron : clock, asynchronous active-low reset
//   sys__pe__peId      : PE identifier, static after reset
//   bus (slave)        : SIMD input handshake and upstream output handshake
//   sui__simd__err     : sticky flag, set when a packet is cut at FIFO_DEPTH words
//   sui__simd__pkt_count : EOP transfers since reset (16-bit, wraps); present
//                          only when SIMD_UPSTREAM_INTF_PERF_CNT_EN is defined
module simd_upstream_intf
   import simd_upstream_intf_pkg::*;
#(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned OOB_W      = 32,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset_poweron,
   input  logic [7:0]                  sys__pe__peId,
   simd_upstream_intf_if.slave         bus,
   output logic                        sui__simd__err
`ifdef SIMD_UPSTREAM_INTF_PERF_CNT_EN
   ,
   output logic [15:0]                 sui__simd__pkt_count
`endif
);
   localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned LAST_I = FIFO_DEPTH - 1;
   localparam logic [CW-1:0] LAST_IDX = LAST_I[CW-1:0];

   // ---------------- input side ----------------
   logic              ready_en_q, in_ready, acc, at_limit, last_eff;
   logic [CW-1:0]     wcnt_q;
   logic [7:0]        tag_q, tag_eff;

   logic [DATA_W+2:0] d_din, d_dout;
   logic              d_pop, d_full, d_empty;
   logic [CW-1:0]     d_count;
   logic [CW+7:0]     p_din, p_dout;
   logic              p_push, p_pop, p_full, p_empty;
   logic [CW-1:0]     p_count;
   logic              unused_fifo_status;

   // The packet FIFO is also checked so a burst of tiny packets cannot
   // overflow it while the packet in flight still holds its entry.
   assign in_ready = ready_en_q && !d_full && !p_full;
   assign bus.sui__simd__ready = in_ready;
   assign acc      = bus.simd__sui__valid && in_ready;
   assign at_limit = (wcnt_q == LAST_IDX);
   assign last_eff = bus.simd__sui__last || at_limit;
   assign tag_eff  = (wcnt_q == '0) ? bus.simd__sui__tag : tag_q;
   assign d_din    = {bus.simd__sui__data, bus.simd__sui__type, last_eff};
   assign p_push   = acc && last_eff;
   assign p_din    = {tag_eff, wcnt_q + 1'b1};
   assign unused_fifo_status = ^{d_empty, d_count, p_count};

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         ready_en_q     <= 1'b0;
         wcnt_q         <= '0;
         tag_q          <= '0;
         sui__simd__err <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         if (acc) begin
            if (wcnt_q == '0) tag_q <= bus.simd__sui__tag;
            wcnt_q <= last_eff ? '0 : wcnt_q + 1'b1;
            if (at_limit && !bus.simd__sui__last) sui__simd__err <= 1'b1;
         end
      end
   end

   simd_upstream_fifo #(.WIDTH(DATA_W + 3), .DEPTH(FIFO_DEPTH)) u_data_fifo (
      .clk(clk), .rst_n(reset_poweron), .push(acc), .din(d_din), .pop(d_pop),
      .dout(d_dout), .full(d_full), .empty(d_empty), .count(d_count)
   );

   simd_upstream_fifo #(.WIDTH(CW + 8), .DEPTH(FIFO_DEPTH)) u_pkt_fifo (
      .clk(clk), .rst_n(reset_poweron), .push(p_push), .din(p_din), .pop(p_pop),
      .dout(p_dout), .full(p_full), .empty(p_empty), .count(p_count)
   );

   // ---------------- output side ----------------
   sui_state_e        state_q, state_d;
   logic              valid_q, valid_d, load_word, xfer;
   logic [1:0]        cntl_q, cntl_d, type_q, type_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [OOB_W-1:0]  oob_q, oob_d;
   logic [7:0]        p_tag;
   logic [CW-1:0]     p_cnt;

   assign p_tag = p_dout[CW+7:CW];
   assign p_cnt = p_dout[CW-1:0];
   assign xfer  = valid_q && bus.sti__sui__ready;

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         cntl_q  <= '0;
         type_q  <= '0;
         data_q  <= '0;
         oob_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         cntl_q  <= cntl_d;
         type_q  <= type_d;
         data_q  <= data_d;
         oob_q   <= oob_d;
      end
   end

   // The output register only changes on entry to HDR or on a transfer,
   // so valid and payload hold steady under backpressure.
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      cntl_d    = cntl_q;
      type_d    = type_q;
      data_d    = data_q;
      oob_d     = oob_q;
      load_word = 1'b0;
      d_pop     = 1'b0;
      p_pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!p_empty) begin
               state_d = ST_HDR;
               valid_d = 1'b1;
               cntl_d  = CNTL_SOP;
               type_d  = TYPE_HDR;
               data_d  = '0;
               data_d[HDR_CNT_LSB  +: 8] = 8'(p_cnt);
               data_d[HDR_TAG_LSB  +: 8] = p_tag;
               data_d[HDR_PEID_LSB +: 8] = sys__pe__peId;
               oob_d   = '0;
               oob_d[OOB_CNT_LSB  +: 8] = 8'(p_cnt);
               oob_d[OOB_TAG_LSB  +: 8] = p_tag;
               oob_d[OOB_PEID_LSB +: 8] = sys__pe__peId;
            end
         end
         ST_HDR: begin
            if (xfer) begin
               state_d   = ST_DATA;
               load_word = 1'b1;
            end
         end
         ST_DATA: begin
            if (xfer) begin
               if (cntl_q == CNTL_EOP) begin
                  state_d = ST_IDLE;
                  p_pop   = 1'b1;
                  valid_d = 1'b0;
                  cntl_d  = '0;
                  type_d  = '0;
                  data_d  = '0;
                  oob_d   = '0;
               end else begin
                  load_word = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load_word) begin
         d_pop   = 1'b1;
         valid_d = 1'b1;
         cntl_d  = d_dout[0] ? CNTL_EOP : CNTL_MOP;
         type_d  = d_dout[2:1];
         data_d  = d_dout[DATA_W+2:3];
         oob_d   = '0;
      end
   end

   assign bus.sui__sti__valid    = valid_q;
   assign bus.sui__sti__cntl     = cntl_q;
   assign bus.sui__sti__type     = type_q;
   assign bus.sui__sti__data     = data_q;
   assign bus.sui__sti__oob_data = oob_q;

`ifdef SIMD_UPSTREAM_INTF_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) sui__simd__pkt_count <= '0;
      else if (p_pop)     sui__simd__pkt_count <= sui__simd__pkt_count + 1'b1;
   end
`endif
endmodule

// File: tb/tb_simd_upstream_intf.sv
module tb_simd_upstream_intf;
   localparam int DW = 64;
   localparam int OW = 32;
   localparam int DEPTH = 16;

   typedef struct {
      logic [1:0]  cntl;
      logic [1:0]  typ;
      logic [63:0] data;
      logic [31:0] oob;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_poweron;
   logic [7:0] pe_id;
   logic       err;
`ifdef SIMD_UPSTREAM_INTF_PERF_CNT_EN
   logic [15:0] pkt_count;
`endif

   simd_upstream_intf_if #(.DATA_W(DW), .OOB_W(OW)) bus ();

   simd_upstream_intf #(.DATA_W(DW), .OOB_W(OW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset_poweron(reset_poweron),
      .sys__pe__peId(pe_id),
      .bus(bus.slave),
      .sui__simd__err(err)
`ifdef SIMD_UPSTREAM_INTF_PERF_CNT_EN
      , .sui__simd__pkt_count(pkt_count)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0, n_err = 0;
   int          cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   exp_t        exp_q[$];
   logic [63:0] pd[$];
   logic [1:0]  pt[$];
   logic [7:0]  ptag;
   logic        err_exp = 1'b0;
   int          acc_cnt = 0;
   int          last_acc_cyc = 0;
   logic        rec_on = 1'b0;
   int          xcyc[$];
   logic [63:0] last_hdr_data = '0;
   logic [31:0] last_hdr_oob = '0;
   logic        hold_v = 1'b0, gap_chk = 1'b0;
   logic [99:0] hold_w, cur;

   // A packet closes on last, or when it reaches DEPTH words; then the
   // expected header and data words are queued in order.
   task automatic model_accept(input logic [63:0] d, input logic [1:0] t,
                               input logic l, input logic [7:0] tg);
      exp_t e;
      int   n;
      if (pd.size() == 0) ptag = tg;
      pd.push_back(d);
      pt.push_back(t);
      n = pd.size();
      if (l || n == DEPTH) begin
         if (!l) err_exp = 1'b1;
         last_acc_cyc = cyc;
         e.cntl = 2'b01;
         e.typ  = 2'b11;
         e.data = (64'(pe_id) << 16) | (64'(ptag) << 8) | 64'(n);
         e.oob  = (32'(pe_id) << 24) | (32'(ptag) << 16) | (32'(n) << 8);
         exp_q.push_back(e);
         for (int i = 0; i < n; i++) begin
            e.cntl = (i == n - 1) ? 2'b10 : 2'b00;
            e.typ  = pt[i];
            e.data = pd[i];
            e.oob  = '0;
            exp_q.push_back(e);
         end
         pd.delete();
         pt.delete();
      end
   endtask

   always @(negedge clk) begin
      if (!reset_poweron) begin
         exp_q.delete();
         pd.delete();
         pt.delete();
         err_exp = 1'b0;
         hold_v  = 1'b0;
         gap_chk = 1'b0;
      end else begin
         chk("err_flag", 128'(err), 128'(err_exp));
         cur = {bus.sui__sti__cntl, bus.sui__sti__type, bus.sui__sti__data, bus.sui__sti__oob_data};
         if (gap_chk) begin
            chk("idle_gap_valid", 128'(bus.sui__sti__valid), 128'(0));
            gap_chk = 1'b0;
         end
         if (hold_v) begin
            chk("hold_valid", 128'(bus.sui__sti__valid), 128'(1));
            chk("hold_word", 128'(cur), 128'(hold_w));
         end
         hold_v = 1'b0;
         if (bus.sui__sti__valid) begin
            if (!bus.sti__sui__ready) begin
               hold_v = 1'b1;
               hold_w = cur;
            end else begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_word: got %h expected nothing", cur);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("out_word", 128'(cur), 128'({e.cntl, e.typ, e.data, e.oob}));
               end
               if (rec_on) xcyc.push_back(cyc);
               if (bus.sui__sti__cntl == 2'b01) begin
                  last_hdr_data = bus.sui__sti__data;
                  last_hdr_oob  = bus.sui__sti__oob_data;
               end
               if (bus.sui__sti__cntl == 2'b10) gap_chk = 1'b1;
            end
         end
         if (bus.simd__sui__valid && bus.sui__simd__ready) begin
            acc_cnt++;
            model_accept(bus.simd__sui__data, bus.simd__sui__type,
                         bus.simd__sui__last, bus.simd__sui__tag);
         end
      end
   end

   // ---------------- upstream ready driver ----------------
   int   rmode = 0;
   int   pidx = 0;
   logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0: bus.sti__sui__ready = 1'b1;
            1: bus.sti__sui__ready = 1'($urandom_range(0, 1));
            2: begin
               bus.sti__sui__ready = pat[pidx];
               pidx = (pidx + 1) % 4;
            end
            default: bus.sti__sui__ready = 1'b0;
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_word(input logic [63:0] d, input logic [1:0] t,
                            input logic l, input logic [7:0] tg);
      bit ok = 0;
      bus.simd__sui__valid = 1'b1;
      bus.simd__sui__data  = d;
      bus.simd__sui__type  = t;
      bus.simd__sui__last  = l;
      bus.simd__sui__tag   = tg;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.sui__simd__ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         $display("FAIL input_accept_timeout: got no ready expected ready within 2000 cycles");
         n_vec++;
         n_err++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.simd__sui__valid = 1'b0;
      bus.simd__sui__last  = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && pd.size() == 0 && !bus.sui__sti__valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         $display("FAIL drain_timeout: got %0d pending words expected 0", exp_q.size());
         n_vec++;
         n_err++;
      end
   endtask

   initial begin
      int a0;
      bit found;
      reset_poweron        = 1'b0;
      pe_id                = 8'h07;
      bus.simd__sui__valid = 1'b0;
      bus.simd__sui__data  = '0;
      bus.simd__sui__type  = '0;
      bus.simd__sui__last  = 1'b0;
      bus.simd__sui__tag   = '0;
      bus.sti__sui__ready  = 1'b0;

      // reset state
      #2;
      chk("rst_valid", 128'(bus.sui__sti__valid), 128'(0));
      chk("rst_word", 128'({bus.sui__sti__cntl, bus.sui__sti__type, bus.sui__sti__data, bus.sui__sti__oob_data}), 128'(0));
      chk("rst_ready", 128'(bus.sui__simd__ready), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      repeat (3) @(posedge clk);
      #1 reset_poweron = 1'b1;
      chk("rel_ready_before_clk", 128'(bus.sui__simd__ready), 128'(0));
      @(posedge clk);
      #1;
      chk("rel_ready_after_clk", 128'(bus.sui__simd__ready), 128'(1));

      // single 3-word packet, tag 5A, ready high: exact latency
      rmode = 0;
      repeat (2) @(posedge clk);
      #1;
      xcyc.delete();
      rec_on = 1'b1;
      send_word(64'h1111_2222_3333_4444, 2'b01, 1'b0, 8'h5A);
      send_word(64'h5555_6666_7777_8888, 2'b10, 1'b0, 8'h00);
      send_word(64'h9999_AAAA_BBBB_CCCC, 2'b00, 1'b1, 8'h00);
      idle_in();
      wait_drain();
      rec_on = 1'b0;
      chk("t1_hdr_oob", 128'(last_hdr_oob), 128'(32'h075A0300));
      chk("t1_hdr_data", 128'(last_hdr_data), 128'(64'h0000_0000_0007_5A03));
      chk("t1_xfer_count", 128'(xcyc.size()), 128'(4));
      if (xcyc.size() == 4)
         for (int k = 0; k < 4; k++)
            chk($sformatf("t1_cycle_%0d", k), 128'(xcyc[k] - last_acc_cyc), 128'(2 + k));

      // backpressure 1,0,0,1 over a 4-word packet
      rmode = 2;
      for (int i = 0; i < 4; i++)
         send_word({$urandom, $urandom}, 2'(i), (i == 3), 8'h21);
      idle_in();
      wait_drain();

      // back-to-back single-word packets, tags 1..3
      rmode = 0;
      for (int i = 1; i <= 3; i++)
         send_word({$urandom, $urandom}, 2'b01, 1'b1, 8'(i));
      idle_in();
      wait_drain();
      chk("pre_oversize_err", 128'(err), 128'(0));

      // oversize: 16 words, none marked last
      for (int i = 0; i < DEPTH; i++)
         send_word({$urandom, $urandom}, 2'b10, 1'b0, 8'h77);
      idle_in();
      wait_drain();
      chk("oversize_hdr_count", 128'(last_hdr_data[7:0]), 128'(16));
      chk("oversize_err", 128'(err), 128'(1));
      repeat (5) @(posedge clk);
      #1;
      chk("oversize_err_sticky", 128'(err), 128'(1));

      // FIFO full: upstream stalled, 20 words offered
      rmode = 3;
      repeat (3) @(posedge clk);
      #1;
      a0 = acc_cnt;
      fork
         begin
            for (int i = 0; i < 20; i++)
               send_word(64'(i) + 64'hF000, 2'b00, (i == 19), 8'h44);
            idle_in();
         end
         begin
            repeat (40) @(posedge clk);
            #1;
            chk("full_accepted", 128'(acc_cnt - a0), 128'(16));
            chk("full_ready_low", 128'(bus.sui__simd__ready), 128'(0));
            rmode = 0;
         end
      join
      wait_drain();

      // randomized packets with random upstream backpressure
      rmode = 1;
      for (int p = 0; p < 30; p++) begin
         int len;
         len = $urandom_range(1, 20);
         for (int w = 0; w < len; w++) begin
            if ($urandom_range(0, 3) == 0) begin
               idle_in();
               @(posedge clk);
               #1;
            end
            send_word({$urandom, $urandom}, 2'($urandom_range(0, 3)), (w == len - 1), 8'($urandom));
         end
      end
      idle_in();
      rmode = 0;
      wait_drain();

      // reset asserted mid-DATA
      for (int i = 0; i < 10; i++)
         send_word({$urandom, $urandom}, 2'b01, (i == 9), 8'h66);
      idle_in();
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (bus.sui__sti__valid && bus.sui__sti__cntl == 2'b00) begin
            found = 1;
            break;
         end
      end
      chk("mid_data_reached", 128'(found), 128'(1));
      #2 reset_poweron = 1'b0;
      #1;
      chk("async_rst_valid", 128'(bus.sui__sti__valid), 128'(0));
      chk("async_rst_word", 128'({bus.sui__sti__cntl, bus.sui__sti__type, bus.sui__sti__data, bus.sui__sti__oob_data}), 128'(0));
      chk("async_rst_ready", 128'(bus.sui__simd__ready), 128'(0));
      chk("async_rst_err", 128'(err), 128'(0));
      pe_id = 8'h3C;
      @(posedge clk);
      @(posedge clk);
      #1 reset_poweron = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_ready", 128'(bus.sui__simd__ready), 128'(1));
      send_word(64'hDEAD_BEEF_0000_0001, 2'b01, 1'b0, 8'h99);
      send_word(64'hDEAD_BEEF_0000_0002, 2'b10, 1'b1, 8'h00);
      idle_in();
      wait_drain();
      chk("post_rst_hdr_data", 128'(last_hdr_data), 128'(64'h0000_0000_003C_9902));
      chk("post_rst_hdr_oob", 128'(last_hdr_oob), 128'(32'h3C99_0200));
      chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish by 2ms");
      $fatal(1, "timeout");
   end
endmodule
